board_mem_arbiter: RTL and testbench
====================================

# board_mem_arbiter

- Shares the single-port board RAM among three requesters:
  - 0: flipper (read/write)
  - 1: validator (read)
  - 2: display scanner (read)
- Sits between those blocks and the board memory in the datapath.
- Grants one access per cycle using round-robin priority; the flipper can lock the port for read-modify-write sequences.
- Routes each read result back to the requester that issued it, and returns a border code for off-board addresses.

## Interface

Parameters:

- ADDR_W, 7 — board address width (10x10 board, cells 0..99)
- DATA_W, 2 — cell width (00 empty, 01 black, 10 white, 11 border)
- N_CELLS, 100 — number of valid addresses
- RD_LAT, 1 — RAM read latency in cycles, legal range 1..3

Ports:

- Clock and reset:
  - clock, in, 1 — single clock, rising edge
  - reset, in, 1 — asynchronous, active-high
- Request side, for x in {0,1,2}:
  - req_x_i, in, 1 — access request
  - we_x_i, in, 1 — write enable; tie low for x=1 and x=2
  - addr_x_i, in, ADDR_W — cell address
  - wdata_x_i, in, DATA_W — write data
  - gnt_x_o, out, 1 — one-cycle grant pulse
  - rvalid_x_o, out, 1 — one-cycle read-data-valid pulse
- lock0_i, in, 1 — flipper holds priority while asserted
- rdata_o, out, DATA_W — read data, shared by all requesters; qualified by rvalid_x_o
- Memory side:
  - mem_addr_o, out, ADDR_W — RAM address
  - mem_we_o, out, 1 — RAM write enable
  - mem_wdata_o, out, DATA_W — RAM write data
  - mem_rdata_i, in, DATA_W — RAM read data, valid RD_LAT cycles after address
- oob_o, out, 1 — one-cycle pulse when a granted access has addr >= N_CELLS

## Operation

Request rules:

- A requester holds req, we, addr and wdata stable from assertion until it sees gnt.
- Eligible requester: req high and its gnt not high in the current cycle. This masking prevents double grants.

Arbitration:

- Round-robin pointer ptr in {0,1,2}; priority order is ptr, ptr+1, ptr+2 (mod 3).
- At each edge, the highest-priority eligible requester w is granted.
- After the grant, ptr becomes (w+1) mod 3.
- Lock exception: if w=0 and lock0_i=1, ptr stays 0.
- If no requester is eligible, ptr is unchanged.

Registered outputs in the grant cycle:

- gnt_w_o=1, mem_addr_o=addr_w.
- mem_we_o = we_w, and 0 if addr_w >= N_CELLS.
- mem_wdata_o = wdata_w.
- Outputs with no grant: mem_we_o=0; mem_addr_o and mem_wdata_o hold their last value.

Read tracking:

- A shift register of depth RD_LAT carries {valid, id[1:0], oob} for each granted read. Writes do not enter it.
- At tail valid: rvalid_id_o=1 for one cycle.
- rdata_o = mem_rdata_i, or 2'b11 if oob.

Out-of-range accesses:

- Reads: the RAM is still addressed, but the result is replaced with 2'b11.
- Writes: suppressed; no rvalid is produced.
- oob_o pulses in the grant cycle in both cases.

Lock:

- While lock0_i=1 and req_0_i is asserted every other cycle, the flipper is granted every second cycle. Other requesters may take the idle alternate cycles.
- lock0_i is ignored when req_0_i=0.

## Timing

Reset values, applied asynchronously:

- All gnt, rvalid, mem_we_o and oob_o = 0.
- mem_addr_o=0, mem_wdata_o=0, rdata_o=0, ptr=0.
- Pipeline cleared; in-flight reads are discarded and never produce rvalid.

Latency and throughput:

- Grant latency: request sampled at edge N; gnt and mem_* are valid in cycle N+1.
- Read data: rvalid_x_o in cycle N+1+RD_LAT.
- Throughput: at most one grant per cycle in total. A single requester is granted at most every 2 cycles because of the gnt masking.

Boundary conditions:

- Simultaneous reqs from all three: granted in round-robin order across consecutive cycles.
- A requester that drops req before its grant: no access occurs.
- Reset asserted mid-lock: ptr returns to 0 and the lock is forgotten.
- rvalid for different ids may occur on consecutive cycles; at most one rvalid is high per cycle.

## Test plan

- Reset, then a single read: req_1_i=1, addr=45, RAM holds 01 at 45, RD_LAT=1.
  - Required: gnt_1_o in cycle 1, mem_addr_o=45, rvalid_1_o in cycle 2, rdata_o=01.
- All three requesters assert at the same edge with ptr=0.
  - Required: gnts in order 0,1,2 on cycles 1,2,3.
  - Required: ptr=0 afterwards; no gnt pulse on any line lasts more than 1 cycle.
- Flipper write: addr=33, wdata=10.
  - Required: mem_we_o=1 for exactly one cycle, mem_wdata_o=10, no rvalid_0_o.
  - Required: a read of 33 by the validator afterwards returns 10.
- Out-of-range access:
  - Validator read at addr=105 → oob_o pulse and rvalid_1_o with rdata_o=11.
  - Flipper write at 120 → oob_o pulse and mem_we_o stays 0.
- Lock: lock0_i=1, flipper read/write alternating at addrs 22/22, validator requesting continuously.
  - Required: flipper granted every 2nd cycle; validator granted only in the alternate cycles.
- RD_LAT=3, reads issued in cycles 1 and 2, reset asserted in cycle 3.
  - Required: no rvalid ever appears; all outputs are 0 immediately on reset.

Source files
------------

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
// Shares the single-port board RAM between the flipper (0, read/write),
// the validator (1, read) and the display scanner (2, read).
//   clock, reset           : rising-edge clock, async active-high reset
//   req/we/addr/wdata_x_i  : per-requester access request, held until gnt
//   gnt_x_o                : one-cycle grant pulse (registered)
//   rvalid_x_o, rdata_o    : read return, rdata_o shared and qualified by rvalid
//   lock0_i                : flipper keeps top priority while set
//   mem_*                  : RAM port; mem_rdata_i valid RD_LAT cycles after address
//   oob_o                  : pulse in the grant cycle of an off-board access
module board_mem_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 2,
    parameter int N_CELLS = 100,
    parameter int RD_LAT  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0_i,
    input  logic              we_0_i,
    input  logic [ADDR_W-1:0] addr_0_i,
    input  logic [DATA_W-1:0] wdata_0_i,
    output logic              gnt_0_o,
    output logic              rvalid_0_o,
    input  logic              req_1_i,
    input  logic              we_1_i,
    input  logic [ADDR_W-1:0] addr_1_i,
    input  logic [DATA_W-1:0] wdata_1_i,
    output logic              gnt_1_o,
    output logic              rvalid_1_o,
    input  logic              req_2_i,
    input  logic              we_2_i,
    input  logic [ADDR_W-1:0] addr_2_i,
    input  logic [DATA_W-1:0] wdata_2_i,
    output logic              gnt_2_o,
    output logic              rvalid_2_o,
    input  logic              lock0_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              oob_o
);
    logic [2:0]             req, we;
    logic [2:0][ADDR_W-1:0] addr;
    logic [2:0][DATA_W-1:0] wdata;

    assign req   = {req_2_i, req_1_i, req_0_i};
    assign we    = {we_2_i, we_1_i, we_0_i};
    assign addr  = {addr_2_i, addr_1_i, addr_0_i};
    assign wdata = {wdata_2_i, wdata_1_i, wdata_0_i};

    logic [2:0]        gnt_q;
    logic [1:0]        ptr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              oob_q;

    // Read tracking. Stage 0 is loaded together with gnt (the address cycle);
    // stage RD_LAT lines up with the cycle the RAM presents the data.
    logic [RD_LAT:0]      vld_pipe_q;
    logic [RD_LAT:0]      oob_pipe_q;
    logic [RD_LAT:0][1:0] id_pipe_q;

    // A requester granted in this cycle still shows its old req; mask it.
    logic [2:0] elig;
    assign elig = req & ~gnt_q;

    logic       win_vld;
    logic [1:0] win_id;
    logic [2:0] slot;

    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        slot    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            slot = {1'b0, ptr_q} + 3'(k);
            if (slot >= 3'd3) slot = slot - 3'd3;
            if (!win_vld && elig[slot[1:0]]) begin
                win_vld = 1'b1;
                win_id  = slot[1:0];
            end
        end
    end

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, sel_oob;
    logic [1:0]        ptr_d;

    assign sel_addr  = addr[win_id];
    assign sel_wdata = wdata[win_id];
    assign sel_we    = we[win_id];
    assign sel_oob   = int'(sel_addr) >= N_CELLS;
    // A locked flipper grant leaves the pointer on itself.
    assign ptr_d     = (lock0_i && win_id == 2'd0) ? 2'd0 :
                       (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            oob_q       <= 1'b0;
            vld_pipe_q  <= '0;
            oob_pipe_q  <= '0;
            id_pipe_q   <= '0;
        end else begin
            gnt_q    <= '0;
            mem_we_q <= 1'b0;
            oob_q    <= 1'b0;
            if (win_vld) begin
                gnt_q[win_id] <= 1'b1;
                mem_addr_q    <= sel_addr;
                mem_we_q      <= sel_we & ~sel_oob;
                mem_wdata_q   <= sel_wdata;
                oob_q         <= sel_oob;
                ptr_q         <= ptr_d;
            end
            // Writes (including suppressed off-board ones) never return data.
            vld_pipe_q[0] <= win_vld & ~sel_we;
            oob_pipe_q[0] <= sel_oob;
            id_pipe_q[0]  <= win_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                oob_pipe_q[i] <= oob_pipe_q[i-1];
                id_pipe_q[i]  <= id_pipe_q[i-1];
            end
        end
    end

    logic       tail_vld;
    logic [1:0] tail_id;
    assign tail_vld = vld_pipe_q[RD_LAT];
    assign tail_id  = id_pipe_q[RD_LAT];

    assign gnt_0_o     = gnt_q[0];
    assign gnt_1_o     = gnt_q[1];
    assign gnt_2_o     = gnt_q[2];
    assign rvalid_0_o  = tail_vld && tail_id == 2'd0;
    assign rvalid_1_o  = tail_vld && tail_id == 2'd1;
    assign rvalid_2_o  = tail_vld && tail_id == 2'd2;
    // Driven to zero between returns so it reads 0 out of reset.
    assign rdata_o     = !tail_vld ? '0 : oob_pipe_q[RD_LAT] ? '1 : mem_rdata_i;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign oob_o       = oob_q;
endmodule

// File: tb/tb_board_mem_arbiter.sv
module tb_board_mem_arbiter;
    localparam int AW = 7;
    localparam int DW = 2;
    localparam int NC = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [2:0]    req = '0;
    logic [2:0]    we = '0;
    logic [AW-1:0] addr [3];
    logic [DW-1:0] wdata [3];
    logic          lock0 = 1'b0;
    wire  [2:0]    gnt, rvl;
    wire  [DW-1:0] rdata, mem_wdata;
    wire  [AW-1:0] mem_addr;
    wire           mem_we, oob;
    logic [DW-1:0] mem_rdata = '0;

    board_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CELLS(NC), .RD_LAT(1)) u_dut (
        .clock(clock), .reset(reset),
        .req_0_i(req[0]), .we_0_i(we[0]), .addr_0_i(addr[0]), .wdata_0_i(wdata[0]),
        .gnt_0_o(gnt[0]), .rvalid_0_o(rvl[0]),
        .req_1_i(req[1]), .we_1_i(we[1]), .addr_1_i(addr[1]), .wdata_1_i(wdata[1]),
        .gnt_1_o(gnt[1]), .rvalid_1_o(rvl[1]),
        .req_2_i(req[2]), .we_2_i(we[2]), .addr_2_i(addr[2]), .wdata_2_i(wdata[2]),
        .gnt_2_o(gnt[2]), .rvalid_2_o(rvl[2]),
        .lock0_i(lock0), .rdata_o(rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .oob_o(oob));

    // Second instance with the deepest read latency, used for the flush-on-reset case.
    logic       rst3 = 1'b1;
    logic       r3_req1 = 1'b0, r3_req2 = 1'b0;
    wire  [2:0] g3, rv3;
    wire  [DW-1:0] rdata3, mem_wdata3;
    wire  [AW-1:0] mem_addr3;
    wire           mem_we3, oob3;

    board_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CELLS(NC), .RD_LAT(3)) u_dut3 (
        .clock(clock), .reset(rst3),
        .req_0_i(1'b0), .we_0_i(1'b0), .addr_0_i(7'd0), .wdata_0_i(2'b10),
        .gnt_0_o(g3[0]), .rvalid_0_o(rv3[0]),
        .req_1_i(r3_req1), .we_1_i(1'b0), .addr_1_i(7'd5), .wdata_1_i(2'b10),
        .gnt_1_o(g3[1]), .rvalid_1_o(rv3[1]),
        .req_2_i(r3_req2), .we_2_i(1'b0), .addr_2_i(7'd6), .wdata_2_i(2'b10),
        .gnt_2_o(g3[2]), .rvalid_2_o(rv3[2]),
        .lock0_i(1'b0), .rdata_o(rdata3),
        .mem_addr_o(mem_addr3), .mem_we_o(mem_we3), .mem_wdata_o(mem_wdata3),
        .mem_rdata_i(2'b01), .oob_o(oob3));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Board RAM with one cycle of read latency, plus the reference copy.
    logic [DW-1:0] ram [128];
    logic [DW-1:0] ref_mem [128];

    initial forever begin
        @(posedge clock);
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    typedef struct { int id; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; logic oob; } gexp_t;
    typedef struct { int id; logic [DW-1:0] data; } rexp_t;
    typedef struct { int cyc; int id; logic [DW-1:0] data; } log_t;
    gexp_t gq[$];
    rexp_t rq[$];
    log_t  glog[$], rlog[$];
    int    we_cnt = 0, oob_cnt = 0;

    // Reference model: round-robin from ptr, skipping whoever was granted
    // last cycle; the memory image is updated in grant order.
    int m_ptr = 0, m_last = -1;
    initial forever begin : model
        int w;
        gexp_t g;
        rexp_t r;
        @(posedge clock);
        if (reset) begin
            m_ptr  = 0;
            m_last = -1;
        end else begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_ptr + k) % 3;
                if (w < 0 && req[c] && c != m_last) w = c;
            end
            m_last = w;
            if (w >= 0) begin
                g.id = w; g.addr = addr[w]; g.oob = (addr[w] >= NC);
                g.we = we[w] && !g.oob; g.wdata = wdata[w];
                gq.push_back(g);
                if (!we[w]) begin
                    r.id = w;
                    r.data = g.oob ? 2'b11 : ref_mem[addr[w]];
                    rq.push_back(r);
                end else if (!g.oob) begin
                    ref_mem[addr[w]] = wdata[w];
                end
                m_ptr = (w == 0 && lock0) ? 0 : (w + 1) % 3;
            end
        end
    end

    // Monitor: compares every DUT output event against the queued expectations.
    logic [2:0] prev_gnt = '0;
    initial forever begin : monitor
        int gid, rid;
        gexp_t g;
        rexp_t r;
        @(negedge clock);
        if (!reset) begin
            chk("gnt_present", 32'(gnt != 0), gq.size());
            if (gnt != 0) begin
                gid = gnt[0] ? 0 : gnt[1] ? 1 : 2;
                chk("gnt_onehot", $countones(gnt), 1);
                chk("gnt_pulse", 32'(gnt & prev_gnt), 0);
                glog.push_back('{cyc, gid, 2'b00});
                if (gq.size() > 0) begin
                    g = gq.pop_front();
                    chk("gnt_id", gid, g.id);
                    chk("mem_addr", 32'(mem_addr), 32'(g.addr));
                    chk("mem_we", 32'(mem_we), 32'(g.we));
                    chk("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
                    chk("oob", 32'(oob), 32'(g.oob));
                end
            end else begin
                chk("idle_we", 32'(mem_we), 0);
                chk("idle_oob", 32'(oob), 0);
            end
            if (mem_we) we_cnt++;
            if (oob) oob_cnt++;
            if (rvl != 0) begin
                rid = rvl[0] ? 0 : rvl[1] ? 1 : 2;
                chk("rvalid_onehot", $countones(rvl), 1);
                rlog.push_back('{cyc, rid, rdata});
                chk("rvalid_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("rvalid_id", rid, r.id);
                    chk("rdata", 32'(rdata), 32'(r.data));
                end
            end
            prev_gnt = gnt;
        end else begin
            prev_gnt = '0;
        end
    end

    int g3cnt = 0, rv3cnt = 0;
    initial forever begin
        @(negedge clock);
        if (!rst3) begin
            if (g3 != 0) g3cnt++;
            if (rv3 != 0) rv3cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic release_granted();
        for (int x = 0; x < 3; x++) if (req[x] && gnt[x]) req[x] = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin tick(); release_granted(); end
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (req != 0 && i < bound) begin tick(); release_granted(); i++; end
        chk("idle_timeout", 32'(req), 0);
    endtask

    task automatic issue(input int x, input logic w, input int a, input logic [DW-1:0] d);
        req[x] = 1'b1; we[x] = w; addr[x] = AW'(a); wdata[x] = d;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 0);
        chk({nm, "_rvalid"}, 32'(rvl), 0);
        chk({nm, "_mem_we"}, 32'(mem_we), 0);
        chk({nm, "_oob"}, 32'(oob), 0);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 0);
        chk({nm, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({nm, "_rdata"}, 32'(rdata), 0);
    endtask

    task automatic chk_rr_three(input string nm);
        int k;
        glog.delete();
        k = cyc;
        issue(0, 1'b0, 10, 2'b00); issue(1, 1'b0, 20, 2'b00); issue(2, 1'b0, 30, 2'b00);
        wait_idle(20);
        run(3);
        chk({nm, "_count"}, glog.size(), 3);
        if (glog.size() >= 3)
            for (int i = 0; i < 3; i++) begin
                chk({nm, "_id"}, glog[i].id, i);
                chk({nm, "_cyc"}, glog[i].cyc, k + 1 + i);
            end
    endtask

    initial begin : stim
        int k, wc0, oc0, f;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
        for (int i = 0; i < 128; i++) begin ram[i] = DW'(i % 4); ref_mem[i] = DW'(i % 4); end

        tick();
        chk_zero("reset");
        tick();
        reset = 1'b0;
        run(2);

        // All three at once from ptr=0.
        chk_rr_three("rr");

        // Single read of cell 45.
        glog.delete(); rlog.delete();
        k = cyc;
        issue(1, 1'b0, 45, 2'b00);
        wait_idle(10);
        run(3);
        chk("rd45_gnts", glog.size(), 1);
        chk("rd45_rvs", rlog.size(), 1);
        if (glog.size() == 1 && rlog.size() == 1) begin
            chk("rd45_gnt_cyc", glog[0].cyc, k + 1);
            chk("rd45_gnt_id", glog[0].id, 1);
            chk("rd45_rv_cyc", rlog[0].cyc, k + 2);
            chk("rd45_rv_id", rlog[0].id, 1);
            chk("rd45_data", 32'(rlog[0].data), 32'(2'b01));
        end

        // Flipper write then validator read-back.
        wc0 = we_cnt; rlog.delete();
        issue(0, 1'b1, 33, 2'b10);
        wait_idle(10);
        run(3);
        chk("wr33_we_cycles", we_cnt - wc0, 1);
        chk("wr33_no_rvalid", rlog.size(), 0);
        issue(1, 1'b0, 33, 2'b00);
        wait_idle(10);
        run(3);
        chk("rd33_rvs", rlog.size(), 1);
        if (rlog.size() == 1) chk("rd33_data", 32'(rlog[0].data), 32'(2'b10));

        // Off-board read and write.
        wc0 = we_cnt; oc0 = oob_cnt; rlog.delete();
        issue(1, 1'b0, 105, 2'b00);
        issue(0, 1'b1, 120, 2'b01);
        wait_idle(10);
        run(3);
        chk("oob_pulses", oob_cnt - oc0, 2);
        chk("oob_no_write", we_cnt - wc0, 0);
        chk("oob_rvs", rlog.size(), 1);
        if (rlog.size() == 1) begin
            chk("oob_rv_id", rlog[0].id, 1);
            chk("oob_rdata", 32'(rlog[0].data), 32'(2'b11));
        end

        // Locked flipper alternating read/write at 22 vs continuous validator.
        lock0 = 1'b1;
        glog.delete();
        issue(0, 1'b0, 22, 2'b00);
        issue(1, 1'b0, $urandom_range(0, 99), 2'b00);
        repeat (20) begin
            tick();
            if (gnt[0]) begin we[0] = ~we[0]; wdata[0] = DW'($urandom_range(0, 3)); end
            if (gnt[1]) addr[1] = AW'($urandom_range(0, 99));
        end
        f = -1;
        foreach (glog[i]) if (f < 0 && glog[i].id == 0) f = i;
        chk("lock_found", 32'(f >= 0 && glog.size() >= f + 8), 1);
        if (f >= 0 && glog.size() >= f + 8)
            for (int i = 0; i < 8; i++) begin
                chk("lock_id", glog[f+i].id, i % 2);
                chk("lock_cyc", glog[f+i].cyc, glog[f].cyc + i);
            end

        // Reset in the middle of the locked sequence.
        reset = 1'b1;
        req = '0;
        gq.delete(); rq.delete();
        ref_mem = ram;
        #1;
        chk_zero("midreset");
        tick(); tick();
        reset = 1'b0;
        run(2);
        chk_rr_three("rr_after_reset");

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            tick();
            release_granted();
            lock0 = ($urandom_range(0, 3) == 0);
            for (int x = 0; x < 3; x++) begin
                if (!req[x]) begin
                    if ($urandom_range(0, 9) < 3)
                        issue(x, (x == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                              ($urandom_range(0, 9) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 99),
                              DW'($urandom_range(0, 3)));
                end else if (!gnt[x] && $urandom_range(0, 29) == 0) begin
                    req[x] = 1'b0;
                end
            end
        end
        tick();
        release_granted();
        req = '0;
        lock0 = 1'b0;
        run(6);
        chk("drain_gnt_q", gq.size(), 0);
        chk("drain_rd_q", rq.size(), 0);

        // RD_LAT=3: reads granted in cycles 1 and 2, reset in cycle 3.
        tick();
        rst3 = 1'b0;
        tick();
        r3_req1 = 1'b1; r3_req2 = 1'b1;
        repeat (2) begin
            tick();
            if (g3[1]) r3_req1 = 1'b0;
            if (g3[2]) r3_req2 = 1'b0;
        end
        tick();
        rst3 = 1'b1;
        r3_req1 = 1'b0; r3_req2 = 1'b0;
        #1;
        chk("lat3_gnts", g3cnt, 2);
        chk("lat3_rst_gnt", 32'(g3), 0);
        chk("lat3_rst_rvalid", 32'(rv3), 0);
        chk("lat3_rst_we", 32'(mem_we3), 0);
        chk("lat3_rst_oob", 32'(oob3), 0);
        chk("lat3_rst_addr", 32'(mem_addr3), 0);
        chk("lat3_rst_wdata", 32'(mem_wdata3), 0);
        chk("lat3_rst_rdata", 32'(rdata3), 0);
        tick(); tick();
        rst3 = 1'b0;
        repeat (8) tick();
        chk("lat3_no_rvalid", rv3cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
